// File: rtl/bit_serializer_if.sv
// bit_serializer_if: parallel-word valid/ready handshake feeding the serializer
interface bit_serializer_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] din;
  logic din_valid;
  logic din_ready;
  modport master(output din, din_valid, input din_ready);
  modport slave(input din, din_valid, output din_ready);
endinterface

// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial shifter with one-word holding buffer for gap-free frames
module bit_serializer #(
  parameter int WIDTH = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic clk,
  input  logic reset,
  bit_serializer_if.slave in_bus,
  output logic ser_out,
  output logic ser_valid,
  output logic frame_done,
  output logic busy
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] shreg, shreg_nx, hold_data, hold_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic hold_full, hold_full_nx, xfer, last;
  assign in_bus.din_ready = !hold_full;
  assign xfer = in_bus.din_valid && !hold_full;
  assign last = (state == SHIFT) && (cnt == CW'(WIDTH - 1));
  assign ser_valid = (state == SHIFT);
  assign ser_out = ser_valid && (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]);
  assign frame_done = last;
  assign busy = ser_valid || hold_full;
  // state registers; reset discards the current word and any buffered word at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      shreg <= '0;
      cnt <= '0;
      hold_data <= '0;
      hold_full <= 1'b0;
    end else begin
      state <= state_nx;
      shreg <= shreg_nx;
      cnt <= cnt_nx;
      hold_data <= hold_nx;
      hold_full <= hold_full_nx;
    end
  end
  // next state: on the last bit, buffered word wins over a bypassed new word
  always_comb begin
    state_nx = state;
    shreg_nx = shreg;
    cnt_nx = cnt;
    hold_nx = hold_data;
    hold_full_nx = hold_full;
    if (state == IDLE) begin
      if (xfer) begin
        shreg_nx = in_bus.din;
        cnt_nx = '0;
        state_nx = SHIFT;
      end
    end else if (last) begin
      cnt_nx = '0;
      if (hold_full) begin
        shreg_nx = hold_data;
        hold_full_nx = 1'b0;
      end else if (xfer) shreg_nx = in_bus.din;
      else state_nx = IDLE;
    end else begin
      shreg_nx = MSB_FIRST ? shreg << 1 : shreg >> 1;
      cnt_nx = cnt + 1'b1;
      if (xfer) begin
        hold_nx = in_bus.din;
        hold_full_nx = 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: scoreboard bench for the 8-bit MSB-first and 4-bit LSB-first serializers
module tb_bit_serializer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic ser_out8, ser_valid8, fd8, busy8;
  logic ser_out4, ser_valid4, fd4, busy4;
  int total = 0;
  int bad = 0;
  logic [1:0] q8[$];
  logic [1:0] q4[$];
  int runs8[$];
  int runs4[$];
  int run8 = 0;
  int run4 = 0;
  bit_serializer_if #(.WIDTH(8)) bus8();
  bit_serializer_if #(.WIDTH(4)) bus4();
  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u8 (
    .clk(clk), .reset(reset), .in_bus(bus8.slave),
    .ser_out(ser_out8), .ser_valid(ser_valid8), .frame_done(fd8), .busy(busy8));
  bit_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u4 (
    .clk(clk), .reset(reset), .in_bus(bus4.slave),
    .ser_out(ser_out4), .ser_valid(ser_valid4), .frame_done(fd4), .busy(busy4));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic miss(input string name);
    total++;
    bad++;
    $display("FAIL %s: got nothing want an entry", name);
  endtask
  task automatic expect8(input string s, input bit fd_last);
    for (int i = 0; i < s.len(); i++) q8.push_back({s[i] == 8'h31, fd_last && (i == s.len() - 1)});
  endtask
  task automatic expect4(input string s);
    for (int i = 0; i < s.len(); i++) q4.push_back({s[i] == 8'h31, i == s.len() - 1});
  endtask
  // monitor for the 8-bit DUT: pops one expected bit per valid cycle, records burst lengths
  always @(negedge clk) begin
    logic [1:0] e;
    if (ser_valid8) begin
      run8++;
      if (q8.size() == 0) miss("bit8 unexpected");
      else begin
        e = q8.pop_front();
        chk("bit8", ser_out8, e[1]);
        chk("fd8", fd8, e[0]);
      end
    end else begin
      chk("idle8", {ser_out8, fd8}, 2'b00);
      if (run8 != 0) begin
        runs8.push_back(run8);
        run8 = 0;
      end
    end
  end
  // monitor for the 4-bit DUT
  always @(negedge clk) begin
    logic [1:0] e;
    if (ser_valid4) begin
      run4++;
      if (q4.size() == 0) miss("bit4 unexpected");
      else begin
        e = q4.pop_front();
        chk("bit4", ser_out4, e[1]);
        chk("fd4", fd4, e[0]);
      end
    end else begin
      chk("idle4", {ser_out4, fd4}, 2'b00);
      if (run4 != 0) begin
        runs4.push_back(run4);
        run4 = 0;
      end
    end
  end
  task automatic send8(input logic [7:0] w, output int n);
    logic r;
    bus8.din = w;
    bus8.din_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      r = bus8.din_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!r && n < 50);
    if (!r) miss("send8 timeout");
  endtask
  task automatic wait_idle8();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy8 && n < 100);
    chk("idle8 timeout", busy8, 1'b0);
    @(posedge clk);
    #1;
  endtask
  task automatic chk_run8(input int exp);
    if (runs8.size() == 0) miss("run8");
    else chk("run8", runs8.pop_front(), exp);
  endtask
  initial begin
    int w, n;
    bus8.din = '0;
    bus8.din_valid = 1'b0;
    bus4.din = '0;
    bus4.din_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst outs", {ser_valid8, ser_out8, fd8, busy8, bus8.din_ready}, 5'b00001);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("post rst outs", {ser_valid8, ser_out8, fd8, busy8, bus8.din_ready}, 5'b00001);
    // single word A5, MSB first
    expect8("10100101", 1'b1);
    send8(8'hA5, w);
    chk("a5 wait", w, 1);
    bus8.din_valid = 1'b0;
    wait_idle8();
    chk_run8(8);
    // streaming F0 0F 3C with valid held high
    expect8("11110000", 1'b1);
    expect8("00001111", 1'b1);
    expect8("00111100", 1'b1);
    send8(8'hF0, w);
    chk("f0 wait", w, 1);
    send8(8'h0F, w);
    chk("0f wait", w, 1);
    chk("hold full ready", bus8.din_ready, 1'b0);
    chk("hold full busy", busy8, 1'b1);
    send8(8'h3C, w);
    chk("3c wait", w, 8);
    bus8.din_valid = 1'b0;
    wait_idle8();
    chk_run8(24);
    // bypass: second word offered only in the frame_done cycle
    expect8("10000000", 1'b1);
    expect8("00000001", 1'b1);
    send8(8'h80, w);
    bus8.din_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fd8 && n < 20);
    chk("byp fd seen", fd8, 1'b1);
    chk("byp ready", bus8.din_ready, 1'b1);
    bus8.din = 8'h01;
    bus8.din_valid = 1'b1;
    @(posedge clk);
    #1;
    bus8.din_valid = 1'b0;
    wait_idle8();
    chk_run8(16);
    // async reset during bit 4 of FF with AA buffered
    expect8("111", 1'b0);
    send8(8'hFF, w);
    send8(8'hAA, w);
    bus8.din_valid = 1'b0;
    chk("aa held", bus8.din_ready, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("mid rst outs", {ser_valid8, ser_out8, fd8, busy8, bus8.din_ready}, 5'b00001);
    @(posedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk_run8(3);
    expect8("00000001", 1'b1);
    send8(8'h01, w);
    chk("01 wait", w, 1);
    bus8.din_valid = 1'b0;
    wait_idle8();
    chk_run8(8);
    // pattern 0x2A as fed to the downstream recognizer
    expect8("00101010", 1'b1);
    send8(8'h2A, w);
    bus8.din_valid = 1'b0;
    wait_idle8();
    chk_run8(8);
    // 4-bit LSB-first DUT
    expect4("1000");
    bus4.din = 4'b0001;
    bus4.din_valid = 1'b1;
    @(negedge clk);
    chk("w4 ready", bus4.din_ready, 1'b1);
    @(posedge clk);
    #1;
    bus4.din_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy4 && n < 50);
    chk("idle4 timeout", busy4, 1'b0);
    @(posedge clk);
    #1;
    if (runs4.size() == 0) miss("run4");
    else chk("run4", runs4.pop_front(), 4);
    chk("q8 empty", q8.size(), 0);
    chk("q4 empty", q4.size(), 0);
    chk("runs8 empty", runs8.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1, "watchdog");
  end
endmodule
